// File: rtl/button_pkg.sv
// Shared types and constants for the push-button front end. The button code
// values match the game controller's encoding and must not be renumbered.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam logic [1:0] BTN_NONE = 2'd2;
    localparam logic [1:0] BTN_1    = 2'd1;
    localparam logic [1:0] BTN_2    = 2'd0;

    // 10 ms debounce and 1 s long press at 27 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 270000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 27000000;

    function automatic logic [1:0] btn_encode(input logic [1:0] level);
        logic [1:0] code;
        code = BTN_NONE;
        if (level[0]) begin
            code = BTN_1;
        end else if (level[1]) begin
            code = BTN_2;
        end
        return code;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned button outputs between the board pins and
// the game controller. The slave side is the conditioner itself.
interface button_conditioner_if;
    logic       s1;
    logic       s2;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_long;
    logic [1:0] btn_code;

    modport master (
        output s1, s2,
        input  btn_level, btn_press, btn_release, btn_long, btn_code
    );

    modport slave (
        input  s1, s2,
        output btn_level, btn_press, btn_release, btn_long, btn_code
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, level and pulse outputs.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_params
        $error("btn_debounce_ch: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
    end

    // Idle level is high (released), so the synchroniser resets to 1s
    logic [1:0] sync_reg;
    logic       sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw_n};
        end
    end

    assign sync = sync_reg[1];

    btn_state_t      state_reg, state_next;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            level_reg, level_next;
    logic            press_reg, press_next;
    logic            release_reg, release_next;

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next, hold_inc;
    logic              long_done_reg, long_done_next;
    logic              long_reg, long_next;

    assign hold_inc = (hold_cnt_reg == HOLD_LAST) ? hold_cnt_reg : hold_cnt_reg + HOLD_ONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            db_cnt_reg    <= '0;
            level_reg     <= 1'b0;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
            long_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            db_cnt_reg    <= db_cnt_next;
            level_reg     <= level_next;
            press_reg     <= press_next;
            release_reg   <= release_next;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_reg  <= hold_cnt_next;
            long_done_reg <= long_done_next;
            long_reg      <= long_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        db_cnt_next    = db_cnt_reg;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        hold_cnt_next  = hold_cnt_reg;
        long_done_next = long_done_reg;
        long_next      = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (!sync) begin
                    state_next  = ST_PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (sync) begin
                    state_next  = ST_IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next     = ST_PRESSED;
                    db_cnt_next    = '0;
                    level_next     = 1'b1;
                    press_next     = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    hold_cnt_next  = '0;
                    long_done_next = 1'b0;
`endif
                end else begin
                    db_cnt_next = db_cnt_reg + DB_ONE;
                end
            end

            ST_PRESSED: begin
`ifdef BTN_LONG_PRESS_EN
                // Fires when the hold count reaches its last value; long_done
                // keeps the saturated counter from re-triggering.
                hold_cnt_next = hold_inc;
                if (hold_inc == HOLD_LAST && !long_done_reg) begin
                    long_next      = 1'b1;
                    long_done_next = 1'b1;
                end
`endif
                if (sync) begin
                    state_next  = ST_RELEASE_WAIT;
                    db_cnt_next = '0;
                end
            end

            ST_RELEASE_WAIT: begin
                if (!sync) begin
                    state_next  = ST_PRESSED;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next   = ST_IDLE;
                    db_cnt_next  = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
`ifdef BTN_LONG_PRESS_EN
    assign long_pulse    = long_reg;
`else
    assign long_pulse    = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner feeding the game controller.
// Long-press pulses are present only when BTN_LONG_PRESS_EN is defined.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    button_conditioner_if.slave  bus
);

    logic [1:0] raw_n;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] code_reg;

    // Bit 0 is s1, bit 1 is s2 throughout
    assign raw_n = {bus.s2, bus.s1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_ch (
            .clk           (sys_clk),
            .rst_n         (sys_rst_n),
            .btn_raw_n     (raw_n[gi]),
            .level         (level[gi]),
            .press_pulse   (press[gi]),
            .release_pulse (rel[gi]),
            .long_pulse    (lng[gi])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            code_reg <= BTN_NONE;
        end else begin
            code_reg <= btn_encode(level);
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_long    = lng;
    assign bus.btn_code    = code_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32.
// Stimulus pushes expected pulse and code events; a negedge monitor pops and compares.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int DB  = 8;
    localparam int LP  = 32;
    localparam int LAT = DB + 3;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    always #5 sys_clk = ~sys_clk;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bif)
    );

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
    } pulse_ev_t;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } code_ev_t;

    pulse_ev_t  pq[$];
    code_ev_t   cq[$];
    logic [1:0] prev_code = 2'd2;

    task automatic check(input string name, input int act, input int exp);
        n_asserts++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic push_pulse(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        pulse_ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l;
        pq.push_back(e);
    endtask

    task automatic push_code(input int c, input logic [1:0] code);
        code_ev_t e;
        e.cyc = c; e.code = code;
        cq.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Monitor: every pulse and every code change must match the next queued event
    always @(negedge sys_clk) begin
        pulse_ev_t pe;
        code_ev_t  ce;
        if ((bif.btn_press | bif.btn_release | bif.btn_long) != 2'b00) begin
            n_asserts++;
            if (pq.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: press=%b release=%b long=%b at cycle %0d, expected none",
                         bif.btn_press, bif.btn_release, bif.btn_long, cyc);
            end else begin
                pe = pq.pop_front();
                if (pe.cyc != cyc || pe.press != bif.btn_press || pe.rel != bif.btn_release ||
                    pe.lng != bif.btn_long) begin
                    n_fail++;
                    $display("FAIL pulse_event: got cyc=%0d press=%b release=%b long=%b, expected cyc=%0d press=%b release=%b long=%b",
                             cyc, bif.btn_press, bif.btn_release, bif.btn_long, pe.cyc, pe.press, pe.rel, pe.lng);
                end else begin
                    $display("ok   pulse_event: cyc=%0d press=%b release=%b long=%b",
                             cyc, bif.btn_press, bif.btn_release, bif.btn_long);
                end
            end
        end
        if (bif.btn_code != prev_code) begin
            n_asserts++;
            if (cq.size() == 0) begin
                n_fail++;
                $display("FAIL code_unexpected: code %0d -> %0d at cycle %0d, expected no change",
                         prev_code, bif.btn_code, cyc);
            end else begin
                ce = cq.pop_front();
                if (ce.cyc != cyc || ce.code != bif.btn_code) begin
                    n_fail++;
                    $display("FAIL code_event: got cyc=%0d code=%0d, expected cyc=%0d code=%0d",
                             cyc, bif.btn_code, ce.cyc, ce.code);
                end else begin
                    $display("ok   code_event: cyc=%0d code=%0d", cyc, bif.btn_code);
                end
            end
        end
        prev_code = bif.btn_code;
    end

    initial begin
        int t0;
        int gaps;
        bif.s1 = 1'b1;
        bif.s2 = 1'b1;
        #2 sys_rst_n = 1'b0;
        wait_n(2);
        check("reset_level",   int'(bif.btn_level),   0);
        check("reset_press",   int'(bif.btn_press),   0);
        check("reset_release", int'(bif.btn_release), 0);
        check("reset_long",    int'(bif.btn_long),    0);
        check("reset_code",    int'(bif.btn_code),    int'(BTN_NONE));
        sys_rst_n = 1'b1;
        wait_n(3);

        // 1: clean press and release on s1
        t0 = cyc;
        bif.s1 = 1'b0;
        push_pulse(t0 + LAT, 2'b01, 2'b00, 2'b00);
        push_code(t0 + LAT + 1, BTN_1);
        wait_n(20);
        check("t1_level_held", int'(bif.btn_level), 1);
        bif.s1 = 1'b1;
        push_pulse(cyc + LAT, 2'b00, 2'b01, 2'b00);
        push_code(cyc + LAT + 1, BTN_NONE);
        wait_n(20);
        check("t1_level_after", int'(bif.btn_level), 0);

        // 2: s2 bounces with 3-cycle phases, never accepted
        for (int i = 0; i < 10; i++) begin
            bif.s2 = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_n(3);
        end
        bif.s2 = 1'b1;
        wait_n(20);
        check("t2_level", int'(bif.btn_level), 0);
        check("t2_code",  int'(bif.btn_code),  int'(BTN_NONE));

        // 3: s1 held 40 cycles with a 4-cycle release glitch at cycle 20
        t0 = cyc;
        gaps = 0;
        push_pulse(t0 + LAT, 2'b01, 2'b00, 2'b00);
        push_code(t0 + LAT + 1, BTN_1);
        for (int i = 0; i < 60; i++) begin
            bif.s1 = (i < 40 && !(i >= 20 && i < 24)) ? 1'b0 : 1'b1;
            if (i == 40) begin
                push_pulse(cyc + LAT, 2'b00, 2'b01, 2'b00);
                push_code(cyc + LAT + 1, BTN_NONE);
            end
            wait_n(1);
            if (cyc >= t0 + LAT && cyc < t0 + 40 + LAT && bif.btn_level[0] == 1'b0) gaps++;
        end
        check("t3_level_gaps", gaps, 0);
        wait_n(5);

        // 4: long press on s1
        t0 = cyc;
        bif.s1 = 1'b0;
        push_pulse(t0 + LAT, 2'b01, 2'b00, 2'b00);
        push_code(t0 + LAT + 1, BTN_1);
`ifdef BTN_LONG_PRESS_EN
        push_pulse(t0 + LAT + LP - 1, 2'b00, 2'b00, 2'b01);
`endif
        wait_n(80);
        bif.s1 = 1'b1;
        push_pulse(cyc + LAT, 2'b00, 2'b01, 2'b00);
        push_code(cyc + LAT + 1, BTN_NONE);
        wait_n(20);

        // 5: simultaneous press, s1 released first then s2
        t0 = cyc;
        bif.s1 = 1'b0;
        bif.s2 = 1'b0;
        push_pulse(t0 + LAT, 2'b11, 2'b00, 2'b00);
        push_code(t0 + LAT + 1, BTN_1);
        wait_n(20);
        check("t5_level_both", int'(bif.btn_level), 3);
        bif.s1 = 1'b1;
        push_pulse(cyc + LAT, 2'b00, 2'b01, 2'b00);
        push_code(cyc + LAT + 1, BTN_2);
        wait_n(5);
        bif.s2 = 1'b1;
        push_pulse(cyc + LAT, 2'b00, 2'b10, 2'b00);
        push_code(cyc + LAT + 1, BTN_NONE);
        wait_n(20);

        // 6: reset while s1 is held, then released during reset
        t0 = cyc;
        bif.s1 = 1'b0;
        push_pulse(t0 + LAT, 2'b01, 2'b00, 2'b00);
        push_code(t0 + LAT + 1, BTN_1);
        wait_n(20);
        push_code(cyc + 1, BTN_NONE);
        #1 sys_rst_n = 1'b0;
        #1;
        check("t6_rst_level", int'(bif.btn_level), 0);
        check("t6_rst_press", int'(bif.btn_press), 0);
        check("t6_rst_code",  int'(bif.btn_code),  int'(BTN_NONE));
        bif.s1 = 1'b1;
        wait_n(3);
        sys_rst_n = 1'b1;
        wait_n(20);
        check("t6_level_after", int'(bif.btn_level), 0);

        check("pulse_queue_drained", pq.size(), 0);
        check("code_queue_drained",  cq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Two-channel front end for the active-low push buttons `s1` and `s2`. Each raw input is synchronised into `sys_clk`, debounced by a per-channel state machine, and converted into stable levels, one-cycle press, release and long-press pulses, and a registered 2-bit button code. The block sits directly upstream of the game controller, and its button code uses the controller's encoding.

## Interface
- `DEBOUNCE_CYCLES`, default 270000 (10 ms at 27 MHz): stable cycles needed to accept a press or a release. Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 27000000 (1 s): cycles in PRESSED before a long-press pulse. Must be > 1.
- `sys_clk`, in, 1: 27 MHz clock. This is the only clock.
- `sys_rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `s1`, in, 1: raw button 1, active-low, asynchronous.
- `s2`, in, 1: raw button 2, active-low, asynchronous.
- `btn_level`, out, 2: debounced pressed level. Bit 0 is s1, bit 1 is s2. 1 means pressed.
- `btn_press`, out, 2: one-cycle pulse when a press is accepted.
- `btn_release`, out, 2: one-cycle pulse when a release is accepted.
- `btn_long`, out, 2: one-cycle pulse once per hold reaching `LONG_PRESS_CYCLES`.
- `btn_code`, out, 2: registered code. 2'd2 = none, 2'd1 = button 1, 2'd0 = button 2.

## Operation
- **Synchroniser:** each raw input passes through 2 flops. The flops reset to 1 (released).
- **Per-channel FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- **IDLE:**
  - If sync = 0: go to PRESS_WAIT and set `db_cnt` = 0.
- **PRESS_WAIT:**
  - If sync = 1: return to IDLE and clear `db_cnt` (bounce rejected, no pulse).
  - Otherwise, if `db_cnt` = `DEBOUNCE_CYCLES`−1: go to PRESSED. Set level = 1, pulse press, clear `hold_cnt` and `long_done`.
  - Otherwise: `db_cnt`++.
- **PRESSED:**
  - `hold_cnt` increments and saturates at `LONG_PRESS_CYCLES`−1.
  - When `hold_cnt` = `LONG_PRESS_CYCLES`−1 and `long_done` = 0: pulse long and set `long_done`.
  - If sync = 1: go to RELEASE_WAIT with `db_cnt` = 0.
- **RELEASE_WAIT:**
  - `hold_cnt` is frozen.
  - If sync = 0: return to PRESSED (release bounce). Clear `db_cnt`; level stays 1 and no pulse is issued.
  - If `db_cnt` = `DEBOUNCE_CYCLES`−1: go to IDLE. Set level = 0 and pulse release.
  - Otherwise: `db_cnt`++.
- **Counter widths:** `db_cnt` is $clog2(`DEBOUNCE_CYCLES`) bits. `hold_cnt` is $clog2(`LONG_PRESS_CYCLES`) bits. Neither counter ever wraps.
- **`btn_code`:** registered each cycle from `btn_level`.
  - s1 pressed → 2'd1.
  - Otherwise s2 pressed → 2'd0.
  - Otherwise → 2'd2.
  - Button 1 has priority when both are pressed.
- **Channel independence:** the two channels do not interact, and simultaneous events on both are processed in parallel.

## Timing
- **Reset values:** `btn_level` = 0, `btn_press` = 0, `btn_release` = 0, `btn_long` = 0, `btn_code` = 2'd2. All FSMs are in IDLE and all counters are 0.
- **Reset mid-operation:** immediately returns to the reset values. No release pulse is generated.
- **Press latency:** raw input sampled low at edge 1 and held → press pulse and level = 1 become visible after edge `DEBOUNCE_CYCLES`+3.
- **Release latency:** same as press, `DEBOUNCE_CYCLES`+3 edges.
- **Code latency:** `btn_code` follows `btn_level` by 1 cycle.
- **Long-press latency:** long pulse appears `LONG_PRESS_CYCLES`−1 edges after entry to PRESSED, excluding cycles spent in RELEASE_WAIT.
- **Pulse width:** every pulse is exactly 1 cycle. Press and release pulses never coincide on one channel.

## Configuration
- **`BTN_LONG_PRESS_EN` defined:** `hold_cnt`, `long_done` and `btn_long` are implemented as described in Operation.
- **`BTN_LONG_PRESS_EN` undefined:** these are removed and `btn_long` is tied to 2'b00. All other behaviour and timing is unchanged.

## Structure
- **Package `button_pkg`:**
  - FSM state enum.
  - Button code constants `BTN_NONE` = 2'd2, `BTN_1` = 2'd1, `BTN_2` = 2'd0, shared with the game controller.
  - Default cycle constants.
- **Sub-module `btn_debounce_ch`:** contains the synchroniser, FSM and counters for one channel. It is instantiated twice.
- **Top level:** the two `btn_debounce_ch` instances plus the `btn_code` register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 8 and `LONG_PRESS_CYCLES` = 32.
1. **Clean press and release:** reset, then `s1` low for 20 cycles, then high.
   - `btn_press`[0] pulses once at edge 11.
   - `btn_code` = 1 at edge 12.
   - Release pulse 11 edges after `s1` returns high, and `btn_code` returns to 2.
2. **Press bounce:** `s2` toggles low/high every 3 cycles for 30 cycles, then stays high.
   - No pulses.
   - `btn_level` stays 0 and `btn_code` stays 2.
3. **Release bounce:** `s1` held low for 40 cycles, with one high glitch of 4 cycles inserted at cycle 20.
   - Exactly 1 press pulse and 1 release pulse in total.
   - `btn_level`[0] has no gap.
4. **Long press:** `s1` held low for 80 cycles.
   - Exactly one `btn_long`[0] pulse, 31 edges after the press pulse.
   - With the macro undefined, `btn_long` stays 0.
5. **Simultaneous press:** `s1` and `s2` go low on the same cycle.
   - Both press pulses occur on the same edge and `btn_code` = 1.
   - Then `s1` is released and `btn_code` = 0 after the release latency.
6. **Reset during hold:** `sys_rst_n` asserted low while in PRESSED.
   - All outputs go to 0 and `btn_code` = 2 immediately.
   - No release pulse after deassert while `s1` is high.
